// File: rtl/mul_alu_writeback_arbiter.sv
// Write-port arbiter merging the multiplier stage-3 result and the ALU result.
// Multiplier always wins; colliding ALU results wait in an in-order overflow FIFO.
module mul_alu_writeback_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       mul_rd_en,
    input  logic [4:0]                 mul_rd_addr,
    input  logic [XLEN-1:0]            mul_ans,
    input  logic                       alu_rd_en,
    input  logic [4:0]                 alu_rd_addr,
    input  logic [XLEN-1:0]            alu_value,
    output logic                       wb_en,
    output logic [4:0]                 wb_addr,
    output logic [XLEN-1:0]            wb_data,
    output logic                       stall_req,
    input  logic [4:0]                 fwd_addr,
    output logic                       fwd_hit,
    output logic [XLEN-1:0]            fwd_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]      fifo_addr_q [DEPTH];
    logic [4:0]      fifo_addr_d [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [XLEN-1:0] fifo_data_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wb_en_q, wb_en_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            ovf_q, ovf_d;

    logic mul_v, alu_v, empty, full, deq, enq_try, enq;

    always_comb begin
        mul_v   = !stall && mul_rd_en && (mul_rd_addr != 5'd0);
        alu_v   = !stall && alu_rd_en && (alu_rd_addr != 5'd0);
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        deq     = !mul_v && !empty;
        // An ALU result is queued whenever something else owns the port this edge.
        enq_try = alu_v && (mul_v || !empty);
        enq     = enq_try && (!full || deq);

        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        wb_en_d     = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        ovf_d       = ovf_q || (enq_try && full && !deq);

        if (mul_v) begin
            wb_en_d   = 1'b1;
            wb_addr_d = mul_rd_addr;
            wb_data_d = mul_ans;
        end else if (!empty) begin
            wb_en_d   = 1'b1;
            wb_addr_d = fifo_addr_q[head_q];
            wb_data_d = fifo_data_q[head_q];
        end else if (alu_v) begin
            wb_en_d   = 1'b1;
            wb_addr_d = alu_rd_addr;
            wb_data_d = alu_value;
        end

        if (deq) begin
            head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
        end
        if (enq) begin
            fifo_addr_d[tail_q] = alu_rd_addr;
            fifo_data_d[tail_q] = alu_value;
            tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
        end
        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (deq && !enq) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            ovf_q       <= ovf_d;
        end
    end

    // Walk oldest to newest so the last match seen is the newest pending value.
    always_comb begin
        logic          fifo_match;
        logic [PW-1:0] idx;
        fwd_hit    = 1'b0;
        fwd_data   = '0;
        fifo_match = 1'b0;
        idx        = '0;
        if (fwd_addr != 5'd0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = PW'((32'(head_q) + i) % DEPTH);
                if ((i < 32'(count_q)) && (fifo_addr_q[idx] == fwd_addr)) begin
                    fifo_match = 1'b1;
                    fwd_data   = fifo_data_q[idx];
                end
            end
            if (fifo_match) begin
                fwd_hit = 1'b1;
            end else if (wb_en_q && (wb_addr_q == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data_q;
            end
        end
    end

    assign wb_en        = wb_en_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign stall_req    = (count_q == CW'(DEPTH));
    assign fifo_count   = count_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_mul_alu_writeback_arbiter.sv
// Directed bench for mul_alu_writeback_arbiter (DEPTH=2, XLEN=32) with
// hand-computed expectations checked by immediate assertions.
module tb_mul_alu_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic        mul_rd_en, alu_rd_en;
    logic [4:0]  mul_rd_addr, alu_rd_addr, fwd_addr;
    logic [31:0] mul_ans, alu_value;
    logic        wb_en, stall_req, fwd_hit, overflow_err;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, fwd_data;
    logic [1:0]  fifo_count;

    int vectors = 0;
    int miscompares = 0;

    mul_alu_writeback_arbiter #(.DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mul_rd_en(mul_rd_en), .mul_rd_addr(mul_rd_addr), .mul_ans(mul_ans),
        .alu_rd_en(alu_rd_en), .alu_rd_addr(alu_rd_addr), .alu_value(alu_value),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_req(stall_req), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .fifo_count(fifo_count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input string tag, input logic en, input logic [4:0] a,
                      input logic [31:0] d, input logic [1:0] cnt);
        check({tag, ".wb_en"}, 64'(wb_en), 64'(en));
        check({tag, ".wb_addr"}, 64'(wb_addr), 64'(a));
        check({tag, ".wb_data"}, 64'(wb_data), 64'(d));
        check({tag, ".count"}, 64'(fifo_count), 64'(cnt));
    endtask

    task automatic drive(input logic me, input logic [4:0] ma, input logic [31:0] md,
                         input logic ae, input logic [4:0] aa, input logic [31:0] ad);
        mul_rd_en = me; mul_rd_addr = ma; mul_ans = md;
        alu_rd_en = ae; alu_rd_addr = aa; alu_value = ad;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; fwd_addr = 5'd0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        wb("reset", 0, 0, 0, 0);
        check("reset.stall_req", 64'(stall_req), 0);
        check("reset.ovf", 64'(overflow_err), 0);
        rst = 1'b0;

        // Uncontested ALU write
        drive(0, 0, 0, 1, 5'd5, 32'h11);
        step();
        wb("alu_direct", 1, 5'd5, 32'h11, 0);

        // Collision: mul wins, ALU queued then drained
        drive(1, 5'd3, 32'hAAAA, 1, 5'd7, 32'h77);
        step();
        wb("collide1", 1, 5'd3, 32'hAAAA, 1);
        fwd_addr = 5'd7; #1;
        check("fwd_q7.hit", 64'(fwd_hit), 1);
        check("fwd_q7.data", 64'(fwd_data), 64'h77);
        fwd_addr = 5'd0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        wb("collide2", 1, 5'd7, 32'h77, 0);
        step();
        wb("idle_hold", 0, 5'd7, 32'h77, 0);

        // Three back-to-back collisions with stall fed back from stall_req
        drive(1, 5'd10, 32'h100, 1, 5'd1, 32'h1);
        step();
        wb("burstA", 1, 5'd10, 32'h100, 1);
        check("burstA.stall_req", 64'(stall_req), 0);
        drive(1, 5'd11, 32'h200, 1, 5'd2, 32'h2);
        step();
        wb("burstB", 1, 5'd11, 32'h200, 2);
        check("burstB.stall_req", 64'(stall_req), 1);
        stall = 1'b1;
        drive(1, 5'd12, 32'h300, 1, 5'd4, 32'h4);
        step();
        wb("burstC", 1, 5'd1, 32'h1, 1);
        check("burstC.stall_req", 64'(stall_req), 0);
        stall = 1'b0;
        step();
        wb("burstD", 1, 5'd12, 32'h300, 2);
        check("burstD.stall_req", 64'(stall_req), 1);
        stall = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        wb("burstE", 1, 5'd2, 32'h2, 1);
        stall = 1'b0;
        // Simultaneous dequeue and enqueue keeps the count
        drive(0, 0, 0, 1, 5'd8, 32'h8);
        step();
        wb("burstF", 1, 5'd4, 32'h4, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        wb("burstG", 1, 5'd8, 32'h8, 0);

        // Forwarding: two pending writes to x9, newest must win
        drive(1, 5'd13, 32'h5, 1, 5'd9, 32'h10);
        step();
        wb("fwd_fill1", 1, 5'd13, 32'h5, 1);
        drive(1, 5'd14, 32'h6, 1, 5'd9, 32'h20);
        step();
        wb("fwd_fill2", 1, 5'd14, 32'h6, 2);
        fwd_addr = 5'd9; #1;
        check("fwd9.hit", 64'(fwd_hit), 1);
        check("fwd9.data", 64'(fwd_data), 64'h20);
        fwd_addr = 5'd0; #1;
        check("fwd0.hit", 64'(fwd_hit), 0);
        check("fwd0.data", 64'(fwd_data), 0);
        fwd_addr = 5'd14; #1;
        check("fwd_wb.hit", 64'(fwd_hit), 1);
        check("fwd_wb.data", 64'(fwd_data), 64'h6);
        fwd_addr = 5'd20; #1;
        check("fwd_miss.hit", 64'(fwd_hit), 0);
        check("fwd_miss.data", 64'(fwd_data), 0);
        fwd_addr = 5'd0;

        // Overflow: full, mul takes the port, ALU enqueue is dropped
        drive(1, 5'd15, 32'h7, 1, 5'd16, 32'h99);
        step();
        wb("ovf", 1, 5'd15, 32'h7, 2);
        check("ovf.flag", 64'(overflow_err), 1);
        drive(1, 5'd17, 32'h8, 0, 0, 0);
        step();
        wb("ovf_sticky", 1, 5'd17, 32'h8, 2);
        check("ovf_sticky.flag", 64'(overflow_err), 1);
        fwd_addr = 5'd16; #1;
        check("ovf_dropped.hit", 64'(fwd_hit), 0);
        fwd_addr = 5'd0;

        // Reset while full discards queued entries
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wb("rst_full", 0, 0, 0, 0);
        check("rst_full.stall_req", 64'(stall_req), 0);
        check("rst_full.ovf", 64'(overflow_err), 0);
        step();
        wb("post_rst1", 0, 0, 0, 0);
        step();
        wb("post_rst2", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_alu_writeback_arbiter.md
Name: mul_alu_writeback_arbiter

Overview:
- Merges two result streams into the register file's single write port: the 3-stage multiplier pipeline's stage-3 output and the single-cycle ALU result.
- Multiplier results have fixed latency and cannot be held, so they always win the port. Colliding ALU results go into a small in-order FIFO.
- Asserts a stall request when the FIFO is full.
- Provides a forwarding lookup so decode can read values not yet written back.

Parameters:
- DEPTH, 2, number of ALU overflow FIFO entries (at least 2).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- stall  in  1  global pipeline stall, the same signal that freezes the multiplier pipeline
- mul_rd_en  in  1  multiplier stage-3 write enable
- mul_rd_addr  in  5  multiplier stage-3 destination
- mul_ans  in  XLEN  multiplier result
- alu_rd_en  in  1  ALU write enable
- alu_rd_addr  in  5  ALU destination
- alu_value  in  XLEN  ALU result
- wb_en  out  1  register-file write enable
- wb_addr  out  5  register-file write address
- wb_data  out  XLEN  register-file write data
- stall_req  out  1  request to the hazard unit to assert stall
- fwd_addr  in  5  forwarding query address
- fwd_hit  out  1  a pending value exists for fwd_addr
- fwd_data  out  XLEN  the pending value
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy
- overflow_err  out  1  sticky illegal-enqueue flag

Behaviour:
- Reset, synchronous on clk when rst=1: wb_en=0, wb_addr=0, wb_data=0, FIFO emptied (fifo_count=0), overflow_err=0. Pending FIFO contents are discarded even mid-operation.
- Valid inputs:
  - mul_v = !stall && mul_rd_en && mul_rd_addr!=0
  - alu_v = !stall && alu_rd_en && alu_rd_addr!=0
  - Sampling only when stall=0 guarantees each stage-3 result is consumed exactly once.
- Per rising edge, write-port priority (the selected write is registered onto wb_*):
  1. mul_v: write the mul result. If alu_v, the ALU result is enqueued.
  2. Else if FIFO not empty: dequeue the head and write it. If alu_v, the ALU result is enqueued in the same edge.
  3. Else if alu_v: write the ALU result directly. FIFO stays empty.
  4. Else wb_en=0. wb_addr and wb_data hold their previous values.
- ALU results always retire in issue order. A direct ALU write happens only when the FIFO is empty.
- FIFO drains while stall=1. stall blocks only new inputs.
- Latency: one cycle from sampling to wb_en for any uncontested input. Worst-case ALU latency is DEPTH+1 cycles plus the intervening mul writes.
- stall_req = (fifo_count==DEPTH), combinational.
  - Upstream must OR stall_req into stall.
  - While full, no enqueue can occur. The head drains because mul_v=0 under stall.
- Overflow: an enqueue attempt with fifo_count==DEPTH and no simultaneous dequeue drops the ALU result and sets overflow_err. overflow_err is sticky until rst.
- Simultaneous enqueue and dequeue leaves fifo_count unchanged. Pointers wrap modulo DEPTH.
- Forwarding (combinational):
  - fwd_addr=0 gives fwd_hit=0 and fwd_data=0.
  - Otherwise search the FIFO entries, newest first. The first match gives fwd_hit=1 with that entry's data.
  - If no FIFO entry matches, compare against wb_en && wb_addr==fwd_addr.
  - No match gives fwd_hit=0, fwd_data=0.
- Precondition, guaranteed by issue logic and not checked here: no WAW between an in-flight multiply and an ALU result pending in the FIFO.

Test Plan:
- Reset, then ALU x5=0x11 alone → the next cycle shows wb_en=1, wb_addr=5, wb_data=0x11, fifo_count stays 0.
- Same edge: mul x3=0xAAAA plus ALU x7=0x77 → cycle 1 writes x3=0xAAAA with fifo_count=1. Cycle 2, no inputs → writes x7=0x77 with fifo_count=0.
- Mul valid on 3 consecutive edges plus ALU x1=1, x2=2, x4=4 on the same edges (DEPTH=2):
  - stall_req=1 after the 2nd edge.
  - With stall driven from stall_req, the 3rd mul and ALU are held. The FIFO drains x1.
  - Final wb order: mul, mul, x1, mul, x2, x4.
- FIFO holds x9=0x10 then x9=0x20, fwd_addr=9 → fwd_hit=1, fwd_data=0x20. With fwd_addr=0 → fwd_hit=0.
- Force an ALU enqueue with stall=0 while full and no dequeue → overflow_err=1, fifo_count stays 2, remains set until rst.
- Assert rst while fifo_count=2 → the next cycle shows wb_en=0, fifo_count=0, stall_req=0, and no queued entries are ever written.
